// File: rtl/dec_sample_capture_pkg.sv
// -----------------------------------------------------------------------------
// dec_sample_capture_pkg
// Shared definitions for the decimated-sample capture block: the default
// sample width produced by the downsampler and the capture FSM state type.
// No ports; imported by dec_sample_capture and its buffer.
// -----------------------------------------------------------------------------
package dec_sample_capture_pkg;

  // Width of one decimated sample as delivered by the downsampler filter_out.
  localparam int DEC_DW = 16;

  // Capture controller states: waiting, filling the buffer, streaming it out.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/dec_sample_capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample buffer: one write port and one registered read port,
// written so that it maps onto a block RAM. Contents are never reset.
//
// Ports
//   i_clk      system clock, rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read enable; o_rd_data only changes on cycles where it is high
//   i_rd_addr  read address
//   o_rd_data  registered read data, valid the cycle after i_rd_en
// -----------------------------------------------------------------------------
module capture_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rd_data;

  // Write port: samples are stored exactly as received.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: the output register holds its value while i_rd_en is low,
  // which lets the controller use it as a pipeline stage that can stall.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dec_sample_capture.sv
// -----------------------------------------------------------------------------
// dec_sample_capture
// Captures a requested number of decimated samples into a buffer, then streams
// them out over a valid/ready interface in the order they were written.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_sample_in  decimated sample from the downsampler
//   i_sample_ce  sample-valid strobe, one sample per high cycle
//   i_start      pulse: begin a capture (honoured only in IDLE)
//   i_abort      pulse: return to IDLE from any state
//   i_length     requested sample count, 0 or >DEPTH means DEPTH
//   o_busy       high while capturing
//   o_done       high while reading out
//   o_captured   samples written in the current or last capture
//   o_m_data     readout sample
//   o_m_valid    readout sample valid
//   i_m_ready    readout consumer ready
//   o_m_last     marks the final readout sample
// -----------------------------------------------------------------------------
module dec_sample_capture
  import dec_sample_capture_pkg::*;
#(
  parameter int DW    = DEC_DW,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_sample_in,
  input  logic          i_sample_ce,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [AW:0]   i_length,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW:0]   o_captured,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic          o_m_last
);

  localparam logic [AW:0]   W_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   W_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  cap_state_t    r_state;
  cap_state_t    w_state_next;
  logic [AW:0]   r_len;
  logic [AW:0]   r_captured;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_pend;
  logic          r_pend_last;
  logic [DW-1:0] r_m_data;
  logic          r_m_valid;
  logic          r_m_last;

  logic [AW:0]   w_len_clamped;
  logic [AW:0]   w_cap_inc;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_out_free;
  logic          w_xfer;
  logic          w_busy;
  logic          w_done;
  logic [DW-1:0] w_rd_data;

  assign w_len_clamped = ((i_length == '0) || (i_length > W_DEPTH)) ? W_DEPTH : i_length;
  assign w_cap_inc     = r_captured + W_ONE;
  assign w_wr_en       = (r_state == ST_CAPTURE) && i_sample_ce && !i_abort;
  assign w_out_free    = !r_m_valid || i_m_ready;
  assign w_xfer        = r_m_valid && i_m_ready;

  // A read is issued while samples remain and the RAM output register is
  // either empty or about to hand its sample to the output register.
  assign w_rd_en = (r_state == ST_READOUT) && (r_rd_ptr < r_len) &&
                   (!r_pend || w_out_free);

  capture_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_sample_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode. Abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_busy = 1'b1;
        if (w_wr_en && (w_cap_inc == r_len)) begin
          w_state_next = ST_READOUT;
        end
      end
      ST_READOUT: begin
        w_done = 1'b1;
        if (w_xfer && r_m_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      w_state_next = ST_IDLE;
    end
  end

  // Capture bookkeeping. An accepted start latches the clamped length and
  // clears the counters; captured is otherwise left alone so it reports the
  // last capture after readout or abort.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_len      <= '0;
      r_captured <= '0;
      r_wr_ptr   <= '0;
    end else if ((r_state == ST_IDLE) && i_start && !i_abort) begin
      r_len      <= w_len_clamped;
      r_captured <= '0;
      r_wr_ptr   <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr   <= r_wr_ptr + A_ONE;
      r_captured <= w_cap_inc;
    end
  end

  // Readout pipeline: RAM output register (r_pend) feeding the output
  // register (r_m_valid). Each stage advances only when the one after it is
  // free, so data and last flag hold during stalls while back-to-back ready
  // gives one sample per cycle. Everything is cleared outside READOUT and on
  // the cycle that leaves it, so m_valid is low in IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
    end else if ((r_state != ST_READOUT) || (w_state_next != ST_READOUT)) begin
      r_rd_ptr    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr    <= r_rd_ptr + W_ONE;
        r_pend_last <= (r_rd_ptr == (r_len - W_ONE));
        r_pend      <= 1'b1;
      end else if (w_out_free) begin
        r_pend      <= 1'b0;
      end
      if (w_out_free) begin
        r_m_valid <= r_pend;
        r_m_last  <= r_pend_last;
        if (r_pend) begin
          r_m_data <= w_rd_data;
        end
      end
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_captured = r_captured;
  assign o_m_data   = r_m_data;
  assign o_m_valid  = r_m_valid;
  assign o_m_last   = r_m_last;

endmodule

// File: tb/tb_dec_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_dec_sample_capture
// Directed bench for dec_sample_capture: capture, readout, stalls, abort,
// reset during readout, ignored start pulses and the full-depth capture.
// -----------------------------------------------------------------------------
module tb_dec_sample_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rstN;
  logic [DW-1:0] sampleIn;
  logic          sampleCe;
  logic          start;
  logic          abortIn;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW:0]   captured;
  logic [DW-1:0] mData;
  logic          mValid;
  logic          mReady;
  logic          mLast;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sampleVec [0:DEPTH-1];

  dec_sample_capture #(
    .DW(DW),
    .DEPTH(DEPTH),
    .AW(AW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_sample_in (sampleIn),
    .i_sample_ce (sampleCe),
    .i_start     (start),
    .i_abort     (abortIn),
    .i_length    (length),
    .o_busy      (busy),
    .o_done      (done),
    .o_captured  (captured),
    .o_m_data    (mData),
    .o_m_valid   (mValid),
    .i_m_ready   (mReady),
    .o_m_last    (mLast)
  );

  always #5 clk = ~clk;

  // Safety net in case the design never reaches the end of a sequence.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic startCapture(input logic [AW:0] len);
    length = len;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Writes sampleVec[first .. first+count-1], one strobe every gap cycles.
  task automatic applyStimulus(input int first, input int count, input int gap);
    for (int k = 0; k < count; k++) begin
      repeat (gap - 1) tick();
      sampleIn = sampleVec[first + k];
      sampleCe = 1'b1;
      tick();
      sampleCe = 1'b0;
    end
  endtask

  task automatic waitValid(input int bound);
    int n = 0;
    while (!mValid && n < bound) begin
      tick();
      n++;
    end
    checkOutput("valid_timeout", {31'd0, mValid}, 32'd1);
  endtask

  // Consumes n beats. mode 0: ready held high; mode 1: ready pattern 1-0-0-1.
  task automatic readStream(input int n, input int mode);
    logic [3:0]    pat = 4'b1001;
    logic          pv;
    logic [DW-1:0] pd;
    logic          pl;
    int beat  = 0;
    int cyc   = 0;
    int first = 0;
    int last  = 0;
    int bound = n * 4 + 20;
    while (beat < n && cyc < bound) begin
      mReady = (mode == 0) ? 1'b1 : pat[cyc % 4];
      pv = mValid;
      pd = mData;
      pl = mLast;
      tick();
      cyc++;
      if (pv && mReady) begin
        checkOutput($sformatf("beat%0d_data", beat), {16'd0, pd}, {16'd0, sampleVec[beat]});
        checkOutput($sformatf("beat%0d_last", beat), {31'd0, pl}, (beat == n - 1) ? 32'd1 : 32'd0);
        if (beat == 0) first = cyc;
        last = cyc;
        beat++;
      end else if (pv) begin
        checkOutput("stall_data", {16'd0, mData}, {16'd0, pd});
        checkOutput("stall_last", {31'd0, mLast}, {31'd0, pl});
      end
    end
    mReady = 1'b0;
    checkOutput("beat_count", beat, n);
    if (mode == 0 && n > 1) begin
      checkOutput("throughput", last - first, n - 1);
    end
  endtask

  initial begin
    logic sawValid;

    rstN     = 1'b0;
    sampleIn = '0;
    sampleCe = 1'b0;
    start    = 1'b0;
    abortIn  = 1'b0;
    length   = '0;
    mReady   = 1'b0;

    // Reset values.
    repeat (3) tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_captured", {21'd0, captured}, 32'd0);
    checkOutput("rst_valid", {31'd0, mValid}, 32'd0);
    checkOutput("rst_last", {31'd0, mLast}, 32'd0);
    checkOutput("rst_data", {16'd0, mData}, 32'd0);
    rstN = 1'b1;
    tick();

    // Four samples at the decimated rate, consumer always ready.
    $display("[TB] length=4 capture");
    sampleVec[0] = 16'h0001;
    sampleVec[1] = 16'h8000;
    sampleVec[2] = 16'h7FFF;
    sampleVec[3] = 16'hFFFF;
    startCapture(11'd4);
    checkOutput("l4_busy", {31'd0, busy}, 32'd1);
    checkOutput("l4_captured_clr", {21'd0, captured}, 32'd0);
    applyStimulus(0, 4, 1625);
    checkOutput("l4_done", {31'd0, done}, 32'd1);
    checkOutput("l4_busy_off", {31'd0, busy}, 32'd0);
    checkOutput("l4_captured", {21'd0, captured}, 32'd4);
    tick();
    tick();
    checkOutput("l4_valid_latency", {31'd0, mValid}, 32'd1);
    checkOutput("l4_first_data", {16'd0, mData}, 32'h0001);
    readStream(4, 0);
    checkOutput("l4_idle_done", {31'd0, done}, 32'd0);
    checkOutput("l4_idle_valid", {31'd0, mValid}, 32'd0);
    checkOutput("l4_hold_captured", {21'd0, captured}, 32'd4);

    // Eight samples, stray start pulses, stalling consumer.
    $display("[TB] length=8 with stalls");
    for (int k = 0; k < 8; k++) sampleVec[k] = 16'(16'hA500 + k * 16'h0111);
    startCapture(11'd8);
    applyStimulus(0, 3, 2);
    startCapture(11'd3);
    checkOutput("l8_start_ign_busy", {31'd0, busy}, 32'd1);
    checkOutput("l8_start_ign_cap", {21'd0, captured}, 32'd3);
    applyStimulus(3, 5, 2);
    checkOutput("l8_done", {31'd0, done}, 32'd1);
    checkOutput("l8_captured", {21'd0, captured}, 32'd8);
    startCapture(11'd2);
    checkOutput("l8_ro_start_ign", {31'd0, done}, 32'd1);
    checkOutput("l8_ro_captured", {21'd0, captured}, 32'd8);
    readStream(8, 1);
    checkOutput("l8_idle_done", {31'd0, done}, 32'd0);
    checkOutput("l8_idle_valid", {31'd0, mValid}, 32'd0);
    checkOutput("l8_hold_captured", {21'd0, captured}, 32'd8);

    // Abort after three samples, colliding with a fourth strobe.
    $display("[TB] abort mid-capture");
    startCapture(11'd8);
    applyStimulus(0, 3, 2);
    abortIn  = 1'b1;
    sampleIn = 16'h1234;
    sampleCe = 1'b1;
    tick();
    abortIn  = 1'b0;
    sampleCe = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_captured", {21'd0, captured}, 32'd3);
    sawValid = 1'b0;
    mReady   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sampleCe = k[0];
      tick();
      if (mValid) sawValid = 1'b1;
    end
    sampleCe = 1'b0;
    mReady   = 1'b0;
    checkOutput("abort_no_valid", {31'd0, sawValid}, 32'd0);
    checkOutput("abort_still_cap", {21'd0, captured}, 32'd3);

    // Reset while the second of six beats is on the bus.
    $display("[TB] reset during readout");
    for (int k = 0; k < 6; k++) sampleVec[k] = 16'(16'h0F00 + k);
    startCapture(11'd6);
    applyStimulus(0, 6, 1);
    waitValid(4);
    checkOutput("rr_beat1", {16'd0, mData}, 32'h0F00);
    mReady = 1'b1;
    tick();
    checkOutput("rr_beat2_valid", {31'd0, mValid}, 32'd1);
    rstN = 1'b0;
    tick();
    rstN   = 1'b1;
    mReady = 1'b0;
    checkOutput("rr_busy", {31'd0, busy}, 32'd0);
    checkOutput("rr_done", {31'd0, done}, 32'd0);
    checkOutput("rr_captured", {21'd0, captured}, 32'd0);
    checkOutput("rr_valid", {31'd0, mValid}, 32'd0);
    checkOutput("rr_last", {31'd0, mLast}, 32'd0);
    checkOutput("rr_data", {16'd0, mData}, 32'd0);
    sampleVec[0] = 16'hC0DE;
    sampleVec[1] = 16'h0BAD;
    startCapture(11'd2);
    applyStimulus(0, 2, 3);
    checkOutput("rr2_captured", {21'd0, captured}, 32'd2);
    readStream(2, 0);
    checkOutput("rr2_idle_done", {31'd0, done}, 32'd0);

    // Zero length means the full buffer depth.
    $display("[TB] length=0 full-depth capture");
    for (int k = 0; k < DEPTH; k++) sampleVec[k] = 16'((k * 16'h0123) ^ 16'h5A5A);
    startCapture(11'd0);
    applyStimulus(0, DEPTH, 1);
    checkOutput("full_done", {31'd0, done}, 32'd1);
    checkOutput("full_captured", {21'd0, captured}, 32'd1024);
    readStream(DEPTH, 0);
    checkOutput("full_idle_done", {31'd0, done}, 32'd0);
    checkOutput("full_idle_valid", {31'd0, mValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
